uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8: data bits per frame, legal range 5..9.
REQ-002 The block SHALL have parameter S_TICK, default 16: s_tick pulses per bit period, even, at least 8.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all logic is posedge.
REQ-004 Port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 Port rx SHALL be an input, 1 bit wide: asynchronous serial line, idle high.
REQ-006 Port s_tick SHALL be an input, 1 bit wide: one-cycle oversampling strobe at S_TICK times the baud rate.
REQ-007 Port cfg_parity SHALL be an input, 2 bits wide: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-008 Port cfg_stop2 SHALL be an input, 1 bit wide: 0 means one stop bit, 1 means two stop bits.
REQ-009 Port rx_done_tick SHALL be an output, 1 bit wide: one-cycle pulse marking a completed frame.
REQ-010 Port data_out SHALL be an output, NB_DATA bits wide: last received data, LSB first on the line.
REQ-011 Port parity_err SHALL be an output, 1 bit wide: parity mismatch in the last frame.
REQ-012 Port frame_err SHALL be an output, 1 bit wide: any sampled stop bit was low in the last frame.

Function
REQ-013 rx SHALL pass through a 2-FF synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE: rx_s==0 SHALL go to START with the tick counter cleared.
REQ-016 START: on the s_tick with counter==(S_TICK/2)-1, rx_s==1 SHALL return to IDLE (false start, no pulse, outputs unchanged); rx_s==0 SHALL go to DATA with the counter and bit index cleared.
REQ-017 DATA: on the s_tick with counter==S_TICK-1, rx_s SHALL shift into the MSB of the shift register, which shifts right.
REQ-018 DATA: after NB_DATA samples, the FSM SHALL go to PARITY if parity is enabled, else to STOP.
REQ-019 PARITY: the bit SHALL be sampled at mid-bit, same rule as data; error when the XOR of data and the parity bit is not 0 (even) or not 1 (odd).
REQ-020 STOP: one or two stop bits SHALL be sampled at mid-bit per cfg_stop2; any 0 SHALL set the frame error.
REQ-021 After the last stop sample the FSM SHALL go to IDLE; back-to-back start bits SHALL then be accepted with no gap.
REQ-022 data_out, parity_err, frame_err and rx_done_tick SHALL all be registered and update on the same edge, one clk after the last stop-bit sample.
REQ-023 data_out, parity_err and frame_err SHALL hold until the next completed frame.
REQ-024 Cycles without s_tick SHALL leave all counters frozen.
REQ-025 The tick counter SHALL be $clog2(S_TICK) bits wide; the bit index SHALL be $clog2(NB_DATA+1) bits wide.
REQ-026 cfg_parity and cfg_stop2 SHALL be latched on the IDLE->START transition; changes mid-frame SHALL be ignored.

Reset
REQ-027 Reset SHALL force state IDLE, all counters 0, shift register 0, data_out 0, parity_err 0, frame_err 0, rx_done_tick 0, and synchronizer flops 1.
REQ-028 Reset mid-frame SHALL abort the frame with no rx_done_tick; reception SHALL resume on the next falling edge after reset deasserts.

Structure
REQ-029 State encodings and parity-mode codes SHALL live in the shared package uart_pkg, reused by the matching transmitter.
REQ-030 The synchronizer SHALL be the sub-module sync_2ff; the FSM and datapath SHALL stay in this module.

Verification (NB_DATA=8, S_TICK=16, s_tick every 4 clk)
REQ-031 The bench SHALL send 0xA5 with no parity and 1 stop: a single rx_done_tick, data_out=0xA5, both errors 0.
REQ-032 The bench SHALL send 0x3C with even parity and parity bit 1: data_out=0x3C, parity_err=1, frame_err=0.
REQ-033 The bench SHALL drive rx low for 4 s_ticks then high: no rx_done_tick, outputs unchanged.
REQ-034 The bench SHALL send 0x81 with cfg_stop2=1 and the second stop bit low: frame_err=1, data_out=0x81.
REQ-035 The bench SHALL assert reset for 1 clk at data bit 3, then send 0x55: only one rx_done_tick, data_out=0x55.
REQ-036 The bench SHALL send 0x00 then 0xFF back-to-back with odd parity: two pulses, both parity_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-mode codes.
// The matching transmitter reuses the same codes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } par_mode_e;

    // The reserved code behaves like "no parity".
    function automatic logic parity_enabled(input par_mode_e mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with run-time parity (none/even/odd) and 1/2 stop bits.
// Configuration is captured at frame start; results are registered and held until the next frame.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned S_TICK  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    input  logic               s_tick,
    input  logic [1:0]         cfg_parity,
    input  logic               cfg_stop2,
    output logic               rx_done_tick,
    output logic [NB_DATA-1:0] data_out,
    output logic               parity_err,
    output logic               frame_err
);

    localparam int unsigned TICK_W = $clog2(S_TICK);
    localparam int unsigned IDX_W  = $clog2(NB_DATA + 1);
    localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(S_TICK / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END = TICK_W'(S_TICK - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NB_DATA - 1);

    logic rx_s;

    uart_state_e          state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NB_DATA-1:0]   shift_q, shift_d;
    par_mode_e            par_mode_q, par_mode_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 done_q, done_d;
    logic [NB_DATA-1:0]   data_out_q, data_out_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    logic mid_hit_c;
    logic end_hit_c;
    logic last_stop_c;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    assign mid_hit_c   = s_tick && (tick_q == TICK_MID);
    assign end_hit_c   = s_tick && (tick_q == TICK_END);
    assign last_stop_c = !stop2_q || stop_idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (mid_hit_c) state_d = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (end_hit_c && (idx_q == IDX_LAST)) begin
                    state_d = parity_enabled(par_mode_q) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (end_hit_c) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (end_hit_c && last_stop_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; counters only advance on s_tick cycles.
    always_comb begin
        tick_d       = tick_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_mode_d   = par_mode_q;
        stop2_d      = stop2_q;
        stop_idx_d   = stop_idx_q;
        perr_acc_d   = perr_acc_q;
        ferr_acc_d   = ferr_acc_q;
        done_d       = 1'b0;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    tick_d     = '0;
                    par_mode_d = par_mode_e'(cfg_parity);
                    stop2_d    = cfg_stop2;
                end
            end
            ST_START: begin
                if (mid_hit_c) begin
                    tick_d     = '0;
                    idx_d      = '0;
                    stop_idx_d = 1'b0;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                end else if (s_tick) begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_DATA: begin
                if (end_hit_c) begin
                    tick_d  = '0;
                    shift_d = {rx_s, shift_q[NB_DATA-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                end else if (s_tick) begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_PARITY: begin
                if (end_hit_c) begin
                    tick_d     = '0;
                    perr_acc_d = ((^shift_q) ^ rx_s) != (par_mode_q == PAR_ODD);
                end else if (s_tick) begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_STOP: begin
                if (end_hit_c) begin
                    tick_d     = '0;
                    stop_idx_d = 1'b1;
                    ferr_acc_d = ferr_acc_q | ~rx_s;
                    if (last_stop_c) begin
                        done_d       = 1'b1;
                        data_out_d   = shift_q;
                        parity_err_d = perr_acc_q;
                        frame_err_d  = ferr_acc_q | ~rx_s;
                    end
                end else if (s_tick) begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                tick_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q       <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_mode_q   <= PAR_NONE;
            stop2_q      <= 1'b0;
            stop_idx_q   <= 1'b0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            done_q       <= 1'b0;
            data_out_q   <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_mode_q   <= par_mode_d;
            stop2_q      <= stop2_d;
            stop_idx_q   <= stop_idx_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            done_q       <= done_d;
            data_out_q   <= data_out_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_done_tick = done_q;
    assign data_out     = data_out_q;
    assign parity_err   = parity_err_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx_cfg;

    localparam int NB      = 8;
    localparam int ST      = 16;
    localparam int CPT     = 4;
    localparam int BIT_CLK = ST * CPT;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          s_tick;
    logic [1:0]    cfg_parity;
    logic          cfg_stop2;
    logic          rx_done_tick;
    logic [NB-1:0] data_out;
    logic          parity_err;
    logic          frame_err;

    int n_vec = 0;
    int n_err = 0;

    // Each record is {data, parity_err, frame_err}.
    logic [NB+1:0] obs_q[$];
    logic [NB+1:0] exp_q[$];
    logic [NB+1:0] last_exp;

    uart_rx_cfg #(
        .NB_DATA (NB),
        .S_TICK  (ST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .rx_done_tick (rx_done_tick),
        .data_out     (data_out),
        .parity_err   (parity_err),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (CPT - 1) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) obs_q.push_back({data_out, parity_err, frame_err});
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        wait_clk(BIT_CLK);
    endtask

    function automatic logic [NB+1:0] model(input logic [NB-1:0] d, input logic [1:0] pm,
                                            input logic pbit, input logic stop2,
                                            input logic s1, input logic s2);
        int   ones;
        logic perr;
        logic ferr;
        ones = $countones(d) + int'(pbit);
        if (pm == 2'b01)      perr = (ones % 2) != 0;
        else if (pm == 2'b10) perr = (ones % 2) != 1;
        else                  perr = 1'b0;
        ferr = !s1 || (stop2 && !s2);
        return {d, perr, ferr};
    endfunction

    // A low final stop bit is released just after mid-bit so the line returns to idle.
    task automatic send_frame(input logic [NB-1:0] d, input logic [1:0] pm, input logic pbit,
                              input logic stop2, input logic s1, input logic s2,
                              input logic scramble);
        logic fin;
        cfg_parity = pm;
        cfg_stop2  = stop2;
        rx = 1'b0;
        wait_clk(12);
        if (scramble) begin
            cfg_parity = 2'($urandom);
            cfg_stop2  = 1'($urandom);
        end
        wait_clk(BIT_CLK - 12);
        for (int i = 0; i < NB; i++) drive_bit(d[i]);
        if (pm == 2'b01 || pm == 2'b10) drive_bit(pbit);
        if (stop2) begin
            drive_bit(s1);
            fin = s2;
        end else begin
            fin = s1;
        end
        if (fin) begin
            drive_bit(1'b1);
        end else begin
            rx = 1'b0;
            wait_clk(48);
            rx = 1'b1;
            wait_clk(BIT_CLK - 48);
        end
        last_exp = model(d, pm, pbit, stop2, s1, s2);
        exp_q.push_back(last_exp);
    endtask

    task automatic check_frames(input string tag);
        wait_clk(20);
        check_eq($sformatf("%s_count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) check_eq($sformatf("%s_frame%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        end
        check_eq($sformatf("%s_hold_data", tag), 32'(data_out), 32'(last_exp[NB+1:2]));
        check_eq($sformatf("%s_hold_perr", tag), 32'(parity_err), 32'(last_exp[1]));
        check_eq($sformatf("%s_hold_ferr", tag), 32'(frame_err), 32'(last_exp[0]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [NB-1:0] d;
        logic [1:0]    pm;
        logic          st2, s1, s2, pb;
        int            ones;

        rx         = 1'b1;
        reset      = 1'b1;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        last_exp   = '0;
        wait_clk(5);
        check_eq("rst_done", 32'(rx_done_tick), 32'd0);
        check_eq("rst_data", 32'(data_out), 32'd0);
        check_eq("rst_perr", 32'(parity_err), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        reset = 1'b0;
        wait_clk(10);

        send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frames("a5_plain");

        send_frame(8'h3C, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frames("3c_even_bad");

        // Short low glitch must be rejected as a false start.
        rx = 1'b0;
        wait_clk(4 * CPT);
        rx = 1'b1;
        wait_clk(200);
        check_frames("false_start");

        send_frame(8'h81, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_clk(200);
        check_frames("81_stop2_low");

        // Abort a frame of 0xF8 during data bit 3, then receive 0x55.
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        rx = 1'b1;
        wait_clk(BIT_CLK / 2);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        wait_clk(200);
        check_eq("mid_rst_data", 32'(data_out), 32'd0);
        last_exp = '0;
        send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frames("mid_rst_55");

        send_frame(8'h00, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'hFF, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frames("b2b_odd");

        for (int k = 0; k < 24; k++) begin
            d    = NB'($urandom);
            pm   = 2'($urandom);
            st2  = 1'($urandom);
            s1   = ($urandom_range(0, 5) != 0);
            s2   = ($urandom_range(0, 5) != 0);
            ones = $countones(d);
            pb   = (pm == 2'b10) ? 1'((ones + 1) % 2) : 1'(ones % 2);
            if ($urandom_range(0, 4) == 0) pb = ~pb;
            send_frame(d, pm, pb, st2, s1, s2, 1'b1);
            if (!last_exp[0]) wait_clk(200);
            else              wait_clk($urandom_range(0, 1) * $urandom_range(0, 100));
            if (k % 4 == 3) check_frames($sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
